// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM sequencer.
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

  // Addressing mode as {P,U}
  typedef enum logic [1:0] {
    AM_DA = 2'b00,
    AM_IA = 2'b01,
    AM_DB = 2'b10,
    AM_IB = 2'b11
  } am_mode_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] PC_IDX     = 4'd15;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/reglist_pri_enc.sv
// Lowest-set-bit encoder and popcount over a 16-bit register list.
module reglist_pri_enc
  import ldm_stm_sequencer_pkg::*;
(
  input  logic [15:0] list,
  output logic [3:0]  idx,
  output logic        valid,
  output logic [4:0]  count
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

  assign count = popcount16(list);

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks the register list in ascending order, issues one
// memory beat per register, then optionally writes back the base register.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       reglist,
  input  logic              is_load,
  input  logic              pre_idx,
  input  logic              up,
  input  logic              wback,
  input  logic [REG_W-1:0]  base_rn,
  input  logic [DATA_W-1:0] base_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [REG_W-1:0]  rf_ra2,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              rf_we3,
  output logic [REG_W-1:0]  rf_wa3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wd,
  output logic              busy,
  output logic              done
);

  seq_state_t        state;
  logic [15:0]       rem_q;
  logic [REG_W-1:0]  cur_reg_q;
  logic [REG_W-1:0]  base_rn_q;
  logic [DATA_W-1:0] cur_addr_q;
  logic [DATA_W-1:0] final_addr_q;
  logic              is_load_q;
  logic              wb_en_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic              busy_q;
  logic              done_q;

  logic [15:0]       enc_in;
  logic [3:0]        enc_idx;
  logic              enc_valid;
  logic [4:0]        enc_cnt;
  logic [DATA_W-1:0] span;
  logic [DATA_W-1:0] first_addr;
  logic [DATA_W-1:0] final_addr;

  // In IDLE the encoder sees the incoming list; in XFER it sees what is left
  // once the current register is retired, giving the next register directly.
  assign enc_in = (state == S_IDLE) ? reglist
                                    : (rem_q & ~(16'h1 << cur_reg_q));

  reglist_pri_enc u_enc (
    .list  (enc_in),
    .idx   (enc_idx),
    .valid (enc_valid),
    .count (enc_cnt)
  );

  assign span       = DATA_W'(enc_cnt) * DATA_W'(WORD_BYTES);
  assign final_addr = up ? (base_val + span) : (base_val - span);

  always_comb begin
    first_addr = base_val;
    case (am_mode_t'({pre_idx, up}))
      AM_IA: first_addr = base_val;
      AM_IB: first_addr = base_val + DATA_W'(WORD_BYTES);
      AM_DA: first_addr = base_val - span + DATA_W'(WORD_BYTES);
      AM_DB: first_addr = base_val - span;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      rem_q        <= '0;
      cur_reg_q    <= '0;
      base_rn_q    <= '0;
      cur_addr_q   <= '0;
      final_addr_q <= '0;
      is_load_q    <= 1'b0;
      wb_en_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_load_q    <= is_load;
            base_rn_q    <= base_rn;
            final_addr_q <= final_addr;
            // A loaded base wins over write-back
            wb_en_q      <= wback && !(is_load && reglist[base_rn]);
            busy_q       <= 1'b1;
            if (!enc_valid) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state      <= S_XFER;
              rem_q      <= reglist;
              cur_reg_q  <= REG_W'(enc_idx);
              cur_addr_q <= first_addr;
              mem_req_q  <= 1'b1;
              mem_we_q   <= !is_load;
            end
          end
        end
        S_XFER: begin
          if (mem_ready) begin
            rem_q <= enc_in;
            if (enc_valid) begin
              cur_reg_q  <= REG_W'(enc_idx);
              cur_addr_q <= cur_addr_q + DATA_W'(WORD_BYTES);
            end else begin
              mem_req_q  <= 1'b0;
              mem_we_q   <= 1'b0;
              cur_reg_q  <= '0;
              cur_addr_q <= '0;
              if (wb_en_q) begin
                state <= S_WB;
              end else begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end
            end
          end
        end
        S_WB: begin
          state  <= S_DONE;
          done_q <= 1'b1;
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = cur_addr_q;
  assign rf_ra2   = cur_reg_q;
  assign busy     = busy_q;
  assign done     = done_q;

  assign mem_wdata = (mem_req_q && mem_we_q) ? rf_rd2 : '0;

  // Load data lands in the same cycle mem_ready is seen
  always_comb begin
    rf_we3 = 1'b0;
    rf_wa3 = '0;
    rf_wd3 = '0;
    pc_we  = 1'b0;
    pc_wd  = '0;
    if (state == S_WB) begin
      rf_we3 = 1'b1;
      rf_wa3 = base_rn_q;
      rf_wd3 = final_addr_q;
    end else if (state == S_XFER && mem_ready && is_load_q) begin
      if (cur_reg_q == REG_W'(PC_IDX)) begin
        pc_we = 1'b1;
        pc_wd = mem_rdata;
      end else begin
        rf_we3 = 1'b1;
        rf_wa3 = cur_reg_q;
        rf_wd3 = mem_rdata;
      end
    end
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Multi-cycle sequencer for ARM load/store-multiple (LDM/STM). It walks a 16-bit register list, drives register-file read/write addresses and memory requests, and then performs optional base write-back through the register-file write port. It sits between the main decoder/controller and the register file plus data memory, and holds the regular datapath while busy.

Parameters:
DATA_W, 32, data/address width
REG_W, 4, register index width (16 architectural registers)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  launch pulse; sampled only in IDLE
reglist  in  16  register list, bit i = Ri
is_load  in  1  1 = LDM, 0 = STM
pre_idx  in  1  P bit (before/after)
up  in  1  U bit (increment/decrement)
wback  in  1  W bit, base write-back enable
base_rn  in  REG_W  base register index
base_val  in  DATA_W  base register value at start
mem_req  out  1  memory access request
mem_we  out  1  memory write enable (STM)
mem_addr  out  DATA_W  word address
mem_wdata  out  DATA_W  store data (= rf_rd2)
mem_rdata  in  DATA_W  load data
mem_ready  in  1  access complete this cycle
rf_ra2  out  REG_W  register-file read address for STM data
rf_rd2  in  DATA_W  register-file read data
rf_we3  out  1  register-file write enable
rf_wa3  out  REG_W  register-file write address
rf_wd3  out  DATA_W  register-file write data
pc_we  out  1  PC write for a load into R15
pc_wd  out  DATA_W  PC write data
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, XFER, WB, DONE. On reset, from any state, go to IDLE asynchronously and force every output to 0. A reset mid-transfer drops the pending request and performs no write-back.
- IDLE: when start=1, latch all inputs, compute N = popcount(reglist) and the start address:
  - IA (P=0, U=1): base
  - IB (P=1, U=1): base+4
  - DA (P=0, U=0): base-4N+4
  - DB (P=1, U=0): base-4N
  - Final address: U ? base+4N : base-4N, modulo 2^DATA_W, wrap allowed.
- IDLE next state: N=0 goes to DONE, with no memory access and no write-back. Otherwise go to XFER with cur_reg = lowest set bit.
- Registers always transfer in ascending index order, lowest at the lowest address.
- XFER, outputs:
  - mem_req=1, mem_addr=cur_addr, mem_we=!is_load, rf_ra2=cur_reg.
  - mem_wdata follows rf_rd2 combinationally.
- XFER, wait: hold all outputs stable while mem_ready=0.
- XFER, on mem_ready=1:
  - Load, cur_reg!=15: rf_we3=1, rf_wa3=cur_reg, rf_wd3=mem_rdata, in the same cycle.
  - Load, cur_reg==15: pc_we=1, pc_wd=mem_rdata, rf_we3=0.
  - Then clear the bit, cur_addr += 4, and advance to the next set bit.
  - After the last register: go to WB if wback && !(is_load && reglist[base_rn]); otherwise go to DONE. When the base is loaded, the loaded value wins.
- WB: rf_we3=1, rf_wa3=base_rn, rf_wd3=final address for one cycle, then DONE. STM with the base in the list stores the original base value.
- DONE: done=1 for one cycle, then IDLE. start is ignored while busy=1.
- Latency with mem_ready tied high:
  - start to done = N+1 cycles without WB.
  - start to done = N+2 cycles with WB.
  - Empty list: 1 cycle.
- mem_req, rf_we3 and pc_we are never asserted outside XFER/WB. rf_we3 and pc_we are never asserted together.

Decomposition:
- Shared package holds:
  - state enum (IDLE, XFER, WB, DONE)
  - WORD_BYTES=4
  - PC_IDX=4'd15
  - addressing-mode encoding {P,U}
- Sub-module reglist_pri_enc: combinational lowest-set-bit index plus valid, and a 16-bit popcount. Used for both the initial N and the per-beat advance.

Test Plan:
- LDMIA R0!, {R1,R3,R5}, base=0x100, mem_ready=1 → reads at 0x100/0x104/0x108 with writes to R1/R3/R5 in that order; WB R0=0x10C; done 5 cycles after start.
- STMDB R13!, {R4-R7,R14}, base=0x1000 → writes at 0xFEC..0xFFC with R4 lowest, R14 at 0xFFC; R13=0xFEC; mem_we=1 on every beat.
- LDMIB R2, {R0,R15}, base=0x200, no W → R0←[0x204], pc_we with [0x208]; no rf write to R15; no WB.
- LDMIA R1!, {R1,R2}, base=0x40 → R1 gets the loaded [0x40], not 0x48; WB state skipped.
- mem_ready held low 3 cycles on the second beat → addr/ra2/mem_we stay stable, no extra rf writes; start pulsed while busy is ignored. Empty reglist → done 1 cycle after start, no mem_req.
- reset asserted in XFER beat 2 → outputs 0 immediately, busy=0, no WB; a subsequent start runs normally.
